// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: program counter, imem request/grant/response, instruction FIFO
// fetch_fifo buffers {inst, pc} pairs; fetch_unit owns the PC and the single-outstanding-request FSM.

module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   s_tvalid,
  input  logic [W-1:0]           s_tdata,
  output logic                   m_tvalid,
  output logic [W-1:0]           m_tdata,
  input  logic                   m_tready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          pop;

  assign m_tvalid = (count != '0);
  assign m_tdata  = mem[rd_ptr];
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      // Flush drops both the pending push and any pop in the same cycle.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (s_tvalid) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({s_tvalid, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   issued_pc;
  logic [CW-1:0] count;
  logic          fire;
  logic          push;
  logic [63:0]   head;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Space is checked against occupancy without crediting this cycle's pop,
  // so the single outstanding response always has a free slot.
  assign imem_req  = !reset && (state == IDLE) && (count < CW'(DEPTH));
  assign imem_addr = fetch_pc;
  assign fire      = imem_req && imem_gnt;
  assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;

  fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect_valid),
    .s_tvalid (push),
    .s_tdata  ({imem_rdata, issued_pc}),
    .m_tvalid (inst_valid),
    .m_tdata  (head),
    .m_tready (inst_ready),
    .count    (count)
  );

  assign inst    = head[63:32];
  assign inst_pc = head[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= {RESET_PC[31:2], 2'b00};
      issued_pc <= {RESET_PC[31:2], 2'b00};
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      // Any request still owed a response on the old path must be drained.
      case (state)
        IDLE:    state <= fire ? DISCARD : IDLE;
        WAIT:    state <= imem_rvalid ? IDLE : DISCARD;
        DISCARD: state <= imem_rvalid ? IDLE : DISCARD;
        default: state <= IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            state     <= WAIT;
            issued_pc <= fetch_pc;
            fetch_pc  <= fetch_pc + 32'd4;
          end
        end
        WAIT:    if (imem_rvalid) state <= IDLE;
        DISCARD: if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a 1-cycle in-order imem model
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] grant_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_data_q[$];
  logic        pending;
  logic [31:0] pend_addr;
  logic        auto_rsp;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic flush_rsp();
    if (pending) begin
      imem_rvalid = 1'b1;
      imem_rdata  = ~pend_addr;
      pending     = 1'b0;
    end
  endtask

  // Memory word at address A is ~A; one response per grant, next cycle when auto_rsp.
  task automatic tick();
    logic        g;
    logic        p;
    logic [31:0] a;
    #1;
    g = imem_req && imem_gnt;
    a = imem_addr;
    p = inst_valid && inst_ready && !redirect_valid && !reset;
    if (p) begin
      pop_pc_q.push_back(inst_pc);
      pop_data_q.push_back(inst);
    end
    if (g) grant_q.push_back(a);
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (g) begin
      pending   = 1'b1;
      pend_addr = a;
    end
    if (pending && auto_rsp) flush_rsp();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic clear_q();
    grant_q.delete();
    pop_pc_q.delete();
    pop_data_q.delete();
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_gnt       = 1'b1;
    inst_ready     = 1'b1;
    auto_rsp       = 1'b1;
    pending        = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    tick();
    tick();
    clear_q();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values, release timing, sequential fetch
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; imem_gnt = 1'b1;
    inst_ready = 1'b1; auto_rsp = 1'b1; pending = 1'b0; pend_addr = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick();
    tick();
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    clear_q();
    reset = 1'b0;
    #1;
    check("rel_req", {31'h0, imem_req}, 32'h1);
    check("rel_addr", imem_addr, 32'h0);
    tick();
    check("lat_e1_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    check("lat_e2_valid", {31'h0, inst_valid}, 32'h1);
    check("lat_e2_inst", inst, 32'hFFFF_FFFF);
    check("lat_e2_pc", inst_pc, 32'h0);
    run(8);
    check("seq_addr0", qat(grant_q, 0), 32'h0);
    check("seq_addr1", qat(grant_q, 1), 32'h4);
    check("seq_addr2", qat(grant_q, 2), 32'h8);
    check("seq_addr3", qat(grant_q, 3), 32'hC);
    check("seq_pc0", qat(pop_pc_q, 0), 32'h0);
    check("seq_pc1", qat(pop_pc_q, 1), 32'h4);
    check("seq_pc2", qat(pop_pc_q, 2), 32'h8);
    check("seq_data2", qat(pop_data_q, 2), 32'hFFFF_FFF7);

    // Backpressure fills the 2-entry FIFO and stops requests
    do_reset();
    inst_ready = 1'b0;
    run(8);
    check("bp_grants", grant_q.size(), 32'd2);
    check("bp_req", {31'h0, imem_req}, 32'h0);
    check("bp_valid", {31'h0, inst_valid}, 32'h1);
    check("bp_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    run(8);
    check("bp_pc0", qat(pop_pc_q, 0), 32'h0);
    check("bp_pc1", qat(pop_pc_q, 1), 32'h4);
    check("bp_data1", qat(pop_data_q, 1), 32'hFFFF_FFFB);
    check("bp_pc2", qat(pop_pc_q, 2), 32'h8);
    check("bp_resume", qat(grant_q, 2), 32'h8);

    // Redirect while WAIT: grant 0x10, redirect to 0x103 before rvalid
    do_reset();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0; imem_gnt = 1'b1; auto_rsp = 1'b0;
    tick();
    check("rdw_grant", qat(grant_q, 0), 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    check("rdw_valid", {31'h0, inst_valid}, 32'h0);
    check("rdw_req_discard", {31'h0, imem_req}, 32'h0);
    flush_rsp();
    tick();
    check("rdw_req", {31'h0, imem_req}, 32'h1);
    check("rdw_addr", imem_addr, 32'h100);
    check("rdw_dropped", {31'h0, inst_valid}, 32'h0);
    auto_rsp = 1'b1;
    run(4);
    check("rdw_pc0", qat(pop_pc_q, 0), 32'h100);
    check("rdw_data0", qat(pop_data_q, 0), 32'hFFFF_FEFF);

    // Redirect in the same cycle as grant
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    check("rg_valid", {31'h0, inst_valid}, 32'h0);
    check("rg_req_discard", {31'h0, imem_req}, 32'h0);
    tick();
    check("rg_empty", {31'h0, inst_valid}, 32'h0);
    check("rg_req", {31'h0, imem_req}, 32'h1);
    check("rg_addr", imem_addr, 32'h200);
    run(4);
    check("rg_pc0", qat(pop_pc_q, 0), 32'h200);
    check("rg_data0", qat(pop_data_q, 0), 32'hFFFF_FDFF);

    // Redirect in the same cycle as rvalid
    do_reset();
    auto_rsp = 1'b0;
    tick();
    flush_rsp();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    check("rv_empty", {31'h0, inst_valid}, 32'h0);
    check("rv_req", {31'h0, imem_req}, 32'h1);
    check("rv_addr", imem_addr, 32'h300);
    auto_rsp = 1'b1;
    run(4);
    check("rv_pc0", qat(pop_pc_q, 0), 32'h300);
    check("rv_data0", qat(pop_data_q, 0), 32'hFFFF_FCFF);

    // Grant stall, then redirect during the stall
    do_reset();
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req", {31'h0, imem_req}, 32'h1);
      check("stall_addr", imem_addr, 32'h0);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect_valid = 1'b0;
    check("stall_rd_addr", imem_addr, 32'h400);
    check("stall_rd_req", {31'h0, imem_req}, 32'h1);
    imem_gnt = 1'b1;
    run(4);
    check("stall_pc0", qat(pop_pc_q, 0), 32'h400);

    // PC wrap
    do_reset();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0; imem_gnt = 1'b1;
    clear_q();
    run(6);
    check("wrap_addr0", qat(grant_q, 0), 32'hFFFF_FFFC);
    check("wrap_addr1", qat(grant_q, 1), 32'h0);
    check("wrap_pc0", qat(pop_pc_q, 0), 32'hFFFF_FFFC);
    check("wrap_pc1", qat(pop_pc_q, 1), 32'h0);

    // Reset mid-WAIT, late response ignored
    do_reset();
    auto_rsp = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rw_req", {31'h0, imem_req}, 32'h0);
    check("rw_addr", imem_addr, 32'h0);
    check("rw_valid", {31'h0, inst_valid}, 32'h0);
    reset = 1'b0;
    clear_q();
    flush_rsp();
    tick();
    check("rw_late_ignored", {31'h0, inst_valid}, 32'h0);
    check("rw_restart", qat(grant_q, 0), 32'h0);
    auto_rsp = 1'b1;
    flush_rsp();
    tick();
    check("rw_valid2", {31'h0, inst_valid}, 32'h1);
    check("rw_pc", inst_pc, 32'h0);
    check("rw_inst", inst, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
